// File: rtl/fp_mul_pkg.sv
// Shared definitions for the double-precision multiplier scheduler.
// Holds the scheduler state encoding, the byte counts of the serial multiplier link
// and the default timeout / inter-transaction gap.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StRecv,
    StResp,
    StGap
  } state_e;

  // 8 bytes of A followed by 8 bytes of B go out; 8 product bytes come back
  localparam int unsigned BytesIn    = 16;
  localparam int unsigned BytesOut   = 8;

  localparam int unsigned DefTimeout = 255;
  localparam int unsigned DefGap     = 2;

endpackage

// File: rtl/fp_mul_sched_if.sv
// Requester-side bus of fp_mul_sched: two operand-pair request channels and two result
// channels sharing one data/error bus.
//   req_valid/req_ready     per-requester operand handshake
//   req_a0/b0, req_a1/b1    IEEE-754 double operands of requester 0/1
//   rsp_valid/rsp_ready     per-requester result handshake
//   rsp_data/rsp_err        shared product and timeout/protocol error flag
// master: requester side, slave: scheduler side.
interface fp_mul_sched_if;
  logic [1:0]  req_valid;
  logic [63:0] req_a0;
  logic [63:0] req_b0;
  logic [63:0] req_a1;
  logic [63:0] req_b1;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   CLK, RESET  clock, synchronous active-high reset
//   i_req       request bits
//   i_take      grant is consumed this cycle (pointer advances)
//   o_gnt       one-hot grant, o_gnt_id its index
// When both request, the one not served last wins; after reset requester 0 wins.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_gnt,
  output logic       o_gnt_id
);

  logic r_last;

  always_comb begin
    if (i_req == 2'b11) o_gnt_id = ~r_last;
    else                o_gnt_id = i_req[1];
    o_gnt = 2'b00;
    if (|i_req) o_gnt = o_gnt_id ? 2'b10 : 2'b01;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_last <= 1'b1;  // "last served = 1" gives requester 0 first pick
    end else if (i_take && |i_req) begin
      r_last <= o_gnt_id;
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Schedules two requesters onto one byte-serial double-precision multiplier.
//   CLK, RESET            clock, synchronous active-high reset
//   bus (slave)           requester operand/result handshakes, see fp_mul_sched_if
//   MUL_ENABLE/DATA_IN    16 operand bytes to the multiplier (A LSB first, then B)
//   MUL_DATA_OUT/READY    product bytes: 7 with READY high, byte 7 on the first low cycle
// One transaction is in flight at a time; WAIT gives up after TIMEOUT cycles.
module fp_mul_sched
  import fp_mul_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter int unsigned GAP     = DefGap
) (
  input  logic                 CLK,
  input  logic                 RESET,
  fp_mul_sched_if.slave        bus,
  output logic                 MUL_ENABLE,
  output logic [7:0]           MUL_DATA_IN,
  input  logic [7:0]           MUL_DATA_OUT,
  input  logic                 MUL_READY
);

  // WAIT and GAP share one counter
  localparam int unsigned CntMax = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax);
  localparam logic [4:0]  LastIn  = 5'(BytesIn - 1);
  localparam logic [4:0]  LastOut = 5'(BytesOut - 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP - 1);

  state_e            r_state, w_state_nxt;
  logic              r_gid;
  logic [63:0]       r_a, r_b, r_result;
  logic [4:0]        r_bcnt;
  logic [CntW-1:0]   r_wcnt;
  logic              r_err;
  logic [1:0]        w_gnt;
  logic              w_gid;
  logic [7:0]        w_send_byte;

  rr_arb2 u_arb (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_req    (bus.req_valid),
    .i_take   (r_state == StIdle),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gid)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (|bus.req_valid) w_state_nxt = StSend;
      StSend: if (r_bcnt == LastIn) w_state_nxt = StWait;
      StWait: begin
        if (MUL_READY)               w_state_nxt = StRecv;
        else if (r_wcnt == WaitLast) w_state_nxt = StResp;
      end
      // Low READY ends RECV either way: byte 7 if 7 bytes arrived, error otherwise
      StRecv: if (!MUL_READY) w_state_nxt = StResp;
      StResp: if (bus.rsp_ready[r_gid]) w_state_nxt = (GAP == 0) ? StIdle : StGap;
      StGap:  if (r_wcnt == GapLast) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= StIdle;
      r_gid    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_bcnt   <= '0;
      r_wcnt   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        StIdle: begin
          if (|bus.req_valid) begin
            r_gid  <= w_gid;
            r_a    <= w_gid ? bus.req_a1 : bus.req_a0;
            r_b    <= w_gid ? bus.req_b1 : bus.req_b0;
            r_bcnt <= '0;
            r_err  <= 1'b0;
          end
        end
        StSend: begin
          r_bcnt <= (r_bcnt == LastIn) ? 5'd0 : r_bcnt + 5'd1;
          r_wcnt <= '0;
        end
        StWait: begin
          if (MUL_READY) begin
            r_result[7:0] <= MUL_DATA_OUT;
            r_bcnt        <= 5'd1;
          end else if (r_wcnt == WaitLast) begin
            r_err    <= 1'b1;
            r_result <= '0;
          end else begin
            r_wcnt <= r_wcnt + CntW'(1);
          end
        end
        StRecv: begin
          if (MUL_READY) begin
            if (r_bcnt < LastOut) begin
              r_result[{r_bcnt[2:0], 3'b000} +: 8] <= MUL_DATA_OUT;
              r_bcnt <= r_bcnt + 5'd1;
            end
          end else if (r_bcnt == LastOut) begin
            r_result[63:56] <= MUL_DATA_OUT;
          end else begin
            r_err    <= 1'b1;
            r_result <= '0;
          end
        end
        StResp:  r_wcnt <= '0;
        StGap:   r_wcnt <= r_wcnt + CntW'(1);
        default: ;
      endcase
    end
  end

  assign w_send_byte = r_bcnt[3] ? r_b[{r_bcnt[2:0], 3'b000} +: 8]
                                 : r_a[{r_bcnt[2:0], 3'b000} +: 8];

  always_comb begin
    MUL_ENABLE    = (r_state == StSend);
    MUL_DATA_IN   = MUL_ENABLE ? w_send_byte : 8'h00;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    // Masked during RESET so no handshake can complete in the reset cycle
    if (!RESET && r_state == StIdle) bus.req_ready = w_gnt;
    if (!RESET && r_state == StResp) bus.rsp_valid[r_gid] = 1'b1;
    bus.rsp_data  = r_result;
    bus.rsp_err   = r_err;
  end

endmodule

// File: tb/tb_fp_mul_sched.sv
// Self-checking bench for fp_mul_sched with a behavioural byte-serial multiplier model.
module tb_fp_mul_sched;

  localparam int unsigned Timeout   = 255;
  localparam int unsigned GapCycles = 2;
  localparam int ModeNormal = 0;
  localparam int ModeNever  = 1;
  localparam int ModeShort  = 2;

  logic       CLK;
  logic       RESET;
  logic       MUL_ENABLE;
  logic [7:0] MUL_DATA_IN;
  logic [7:0] MUL_DATA_OUT;
  logic       MUL_READY;

  fp_mul_sched_if bus ();

  fp_mul_sched #(
    .TIMEOUT (Timeout),
    .GAP     (GapCycles)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .bus          (bus.slave),
    .MUL_ENABLE   (MUL_ENABLE),
    .MUL_DATA_IN  (MUL_DATA_IN),
    .MUL_DATA_OUT (MUL_DATA_OUT),
    .MUL_READY    (MUL_READY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mul_ref(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rand_dbl();
    logic [63:0] v;
    v[63]    = 1'($urandom_range(0, 1));
    v[62:52] = 11'(993 + $urandom_range(0, 60));
    v[51:32] = 20'($urandom);
    v[31:0]  = $urandom;
    return v;
  endfunction

  // Behavioural multiplier: collects 16 ENABLE bytes, multiplies as reals, answers after
  // a random latency. Drives random junk on READY while it is not expected to answer.
  int         mul_mode = ModeNormal;
  int         mul_lat  = 0;
  logic [7:0] seen [16];
  int         seen_n = 0;
  int         wait_entry = 0;

  initial begin : mul_model
    int phase, dly, k, hi;
    logic [63:0] ma, mb, prod;
    phase = 0; dly = 0; k = 0; hi = 7; prod = '0; ma = '0; mb = '0;
    MUL_READY = 1'b0;
    MUL_DATA_OUT = 8'h00;
    forever begin
      @(negedge CLK);
      #2;
      if (RESET) begin
        phase = 0; seen_n = 0;
        MUL_READY = 1'b0; MUL_DATA_OUT = 8'h00;
      end else begin
        case (phase)
          0: begin
            if (mul_mode != ModeNever) begin
              MUL_READY    = 1'($urandom_range(0, 1));
              MUL_DATA_OUT = 8'($urandom);
            end else begin
              MUL_READY = 1'b0;
            end
            if (MUL_ENABLE) begin
              if (seen_n == 16) seen_n = 0;
              seen[seen_n] = MUL_DATA_IN;
              seen_n++;
              if (seen_n == 16) begin
                wait_entry = cyc + 1;
                for (int i = 0; i < 8; i++) begin
                  ma[8*i +: 8] = seen[i];
                  mb[8*i +: 8] = seen[i+8];
                end
                prod = mul_ref(ma, mb);
                hi   = (mul_mode == ModeShort) ? 4 : 7;
                dly  = mul_lat;
                if (mul_mode != ModeNever) phase = 1;
              end
            end
          end
          1: begin
            MUL_READY = 1'b0;
            if (dly == 0) begin phase = 2; k = 0; end
            else dly--;
          end
          default: begin
            if (k < hi) begin
              MUL_READY = 1'b1; MUL_DATA_OUT = prod[8*k +: 8]; k++;
            end else begin
              MUL_READY = 1'b0; MUL_DATA_OUT = prod[63:56]; phase = 0;
            end
          end
        endcase
      end
    end
  end

  // One transaction from requester id; during a hold the other requester asserts
  // req_valid and rsp_ready, both of which must be ignored.
  task automatic run_txn(input int id, input logic [63:0] a, input logic [63:0] b,
                         input int mode, input int hold, input logic [63:0] exp_data,
                         input logic exp_err, input logic chk_data);
    int n, t0;
    logic [1:0] oh;
    oh = (id == 0) ? 2'b01 : 2'b10;
    mul_mode = mode;
    mul_lat  = $urandom_range(0, 6);
    @(negedge CLK);
    if (id == 0) begin bus.req_a0 = a; bus.req_b0 = b; end
    else         begin bus.req_a1 = a; bus.req_b1 = b; end
    bus.req_valid = oh;
    bus.rsp_ready = (hold == 0) ? oh : ~oh;
    #1;
    n = 0;
    while (bus.req_ready == 2'b00 && n < 20) begin @(negedge CLK); #1; n++; end
    check_eq("grant", 64'(bus.req_ready), 64'(oh));
    @(negedge CLK);
    bus.req_valid = (hold > 0) ? ~oh : 2'b00;
    #1;
    n = 0;
    while (bus.rsp_valid == 2'b00 && n < 400) begin @(negedge CLK); #1; n++; end
    t0 = cyc;
    check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
    check_eq("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    if (chk_data) check_eq("rsp_data", bus.rsp_data, exp_data);
    if (mode == ModeNever) check_eq("timeout_lat", 64'(t0 - wait_entry), 64'(Timeout));
    check_eq("en_count", 64'(seen_n), 64'd16);
    for (int i = 0; i < 8; i++) begin
      check_eq("en_byte_a", 64'(seen[i]), 64'(a[8*i +: 8]));
      check_eq("en_byte_b", 64'(seen[i+8]), 64'(b[8*i +: 8]));
    end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge CLK); #1;
        check_eq("hold_valid", 64'(bus.rsp_valid), 64'(oh));
        check_eq("hold_err", 64'(bus.rsp_err), 64'(exp_err));
        if (chk_data) check_eq("hold_data", bus.rsp_data, exp_data);
        check_eq("hold_enable", 64'(MUL_ENABLE), 64'd0);
        check_eq("hold_no_grant", 64'(bus.req_ready), 64'd0);
      end
      @(negedge CLK);
      bus.rsp_ready = oh;
      bus.req_valid = 2'b00;
    end
    @(negedge CLK); #1;
    check_eq("rsp_done", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = 2'b00;
  endtask

  initial begin : main
    logic [63:0] a0, b0, a1, b1;
    logic [1:0]  exp_oh;
    int n, id, hold;

    RESET = 1'b1;
    a0 = rand_dbl(); b0 = rand_dbl(); a1 = rand_dbl(); b1 = rand_dbl();
    bus.req_a0 = a0; bus.req_b0 = b0; bus.req_a1 = a1; bus.req_b1 = b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    mul_mode = ModeNormal;
    mul_lat  = 3;
    repeat (3) @(negedge CLK);
    #1;
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_rsp_data", bus.rsp_data, 64'd0);
    check_eq("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check_eq("rst_enable", 64'(MUL_ENABLE), 64'd0);
    check_eq("rst_data_in", 64'(MUL_DATA_IN), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;

    // Both requesters valid from reset: grants must alternate starting at 0
    exp_oh = 2'b01;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (bus.req_ready == 2'b00 && n < 40) begin @(negedge CLK); #1; n++; end
      check_eq("alt_grant", 64'(bus.req_ready), 64'(exp_oh));
      @(negedge CLK); #1;
      n = 0;
      while (bus.rsp_valid == 2'b00 && n < 400) begin @(negedge CLK); #1; n++; end
      check_eq("alt_rsp_valid", 64'(bus.rsp_valid), 64'(exp_oh));
      check_eq("alt_rsp_data", bus.rsp_data, exp_oh[0] ? mul_ref(a0, b0) : mul_ref(a1, b1));
      check_eq("alt_rsp_err", 64'(bus.rsp_err), 64'd0);
      @(negedge CLK); #1;
      check_eq("alt_rsp_1cyc", 64'(bus.rsp_valid), 64'd0);
      exp_oh = ~exp_oh;
    end
    @(negedge CLK);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    repeat (4) @(negedge CLK);

    // 1.5 * 2.0 = 3.0
    run_txn(0, 64'h3FF8000000000000, 64'h4000000000000000, ModeNormal, 0,
            64'h4008000000000000, 1'b0, 1'b1);

    a1 = rand_dbl(); b1 = rand_dbl();
    run_txn(1, a1, b1, ModeNormal, 20, mul_ref(a1, b1), 1'b0, 1'b1);

    a0 = rand_dbl(); b0 = rand_dbl();
    run_txn(0, a0, b0, ModeNever, 0, 64'd0, 1'b1, 1'b1);

    a1 = rand_dbl(); b1 = rand_dbl();
    run_txn(1, a1, b1, ModeShort, 0, 64'd0, 1'b1, 1'b0);

    a1 = rand_dbl(); b1 = rand_dbl();
    run_txn(1, a1, b1, ModeNormal, 2, mul_ref(a1, b1), 1'b0, 1'b1);

    // Reset while B byte 1 (overall byte 9) is on the bus
    a0 = rand_dbl(); b0 = rand_dbl();
    mul_mode = ModeNormal;
    @(negedge CLK);
    bus.req_a0 = a0; bus.req_b0 = b0; bus.req_valid = 2'b01;
    #1;
    n = 0;
    while (bus.req_ready == 2'b00 && n < 20) begin @(negedge CLK); #1; n++; end
    check_eq("mid_grant", 64'(bus.req_ready), 64'h1);
    @(negedge CLK);
    bus.req_valid = 2'b00;
    repeat (9) @(negedge CLK);
    #1;
    check_eq("mid_byte9", 64'(MUL_DATA_IN), 64'(b0[15:8]));
    RESET = 1'b1;
    @(negedge CLK); #1;
    check_eq("mid_req_ready", 64'(bus.req_ready), 64'd0);
    check_eq("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("mid_rsp_data", bus.rsp_data, 64'd0);
    check_eq("mid_rsp_err", 64'(bus.rsp_err), 64'd0);
    check_eq("mid_enable", 64'(MUL_ENABLE), 64'd0);
    check_eq("mid_data_in", 64'(MUL_DATA_IN), 64'd0);
    RESET = 1'b0;
    a0 = rand_dbl(); b0 = rand_dbl();
    run_txn(0, a0, b0, ModeNormal, 0, mul_ref(a0, b0), 1'b0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      id   = $urandom_range(0, 1);
      hold = $urandom_range(0, 3);
      a0 = rand_dbl(); b0 = rand_dbl();
      run_txn(id, a0, b0, ModeNormal, hold, mul_ref(a0, b0), 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
